// File: rtl/lbm_ctrl_pkg.sv
// lbm_ctrl_pkg: shared state encoding, phase codes and default grid geometry for the LBM sweep scheduler
package lbm_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_COLLIDE, S_DRAIN_C, S_STREAM, S_DRAIN_S, S_DONE} state_t;
  localparam logic [1:0] PHASE_IDLE = 2'd0;
  localparam logic [1:0] PHASE_COLLIDE = 2'd1;
  localparam logic [1:0] PHASE_STREAM = 2'd2;
  localparam int DEF_GRID_W = 16;
  localparam int DEF_GRID_H = 16;
  localparam int DEF_PIPE_LAT = 3;
  localparam int DEF_STEP_WIDTH = 16;
endpackage

// File: rtl/lbm_sweep_ctrl_if.sv
// lbm_sweep_ctrl_if: cell read-issue and write-back signals between sweep scheduler (master) and datapath (slave)
interface lbm_sweep_ctrl_if import lbm_ctrl_pkg::*; #(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H
);
  localparam int A_W = $clog2(GRID_W * GRID_H);
  logic dp_ready;
  logic rd_valid;
  logic [A_W-1:0] rd_addr;
  logic [$clog2(GRID_H)-1:0] row;
  logic [$clog2(GRID_W)-1:0] col;
  logic wr_en;
  logic [A_W-1:0] wr_addr;
  logic edge_flag;
  modport master (input dp_ready, output rd_valid, rd_addr, row, col, wr_en, wr_addr, edge_flag);
  modport slave (output dp_ready, input rd_valid, rd_addr, row, col, wr_en, wr_addr, edge_flag);
endinterface

// File: rtl/lbm_wb_delay.sv
// lbm_wb_delay: PIPE_LAT-deep {valid, addr} write-back delay line; o_any_valid flags cells still behind the output stage
module lbm_wb_delay #(
  parameter int PIPE_LAT = 3,
  parameter int A_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic [A_W-1:0] i_addr,
  output logic o_valid,
  output logic [A_W-1:0] o_addr,
  output logic o_any_valid
);
  logic [PIPE_LAT-1:0] r_valid;
  logic [A_W-1:0] r_addr [PIPE_LAT];
  // shift every cycle regardless of datapath stalls; reset flushes all pending write-backs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_addr[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0] <= i_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end
  // OR of every stage ahead of the output; zero means the emerging cell is the youngest in flight
  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) o_any_valid = o_any_valid | r_valid[i];
  end
  assign o_valid = r_valid[PIPE_LAT-1];
  assign o_addr = r_addr[PIPE_LAT-1];
endmodule

// File: rtl/lbm_sweep_ctrl.sv
// lbm_sweep_ctrl: collide/stream grid-sweep scheduler; define LBM_SWEEP_BOUNDARY_EN to generate the boundary-cell edge_flag
module lbm_sweep_ctrl import lbm_ctrl_pkg::*; #(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic [STEP_WIDTH-1:0] num_steps,
  output logic busy,
  output logic done,
  output logic [1:0] phase,
  output logic [STEP_WIDTH-1:0] step_count,
  lbm_sweep_ctrl_if.master io
);
  localparam int N = GRID_W * GRID_H;
  localparam int A_W = $clog2(N);
  localparam int R_W = $clog2(GRID_H);
  localparam int C_W = $clog2(GRID_W);
  state_t r_state, w_next;
  logic [R_W-1:0] r_row;
  logic [C_W-1:0] r_col;
  logic [STEP_WIDTH-1:0] r_step, r_num;
  logic [A_W-1:0] w_addr, w_wr_addr;
  logic w_issue, w_accept, w_last_cell, w_col_wrap, w_wr_en, w_any_valid, w_final_wb;
  assign w_issue = (r_state == S_COLLIDE) || (r_state == S_STREAM);
  assign w_accept = w_issue & io.dp_ready;
  assign w_addr = A_W'(r_row) * A_W'(GRID_W) + A_W'(r_col);
  assign w_last_cell = w_addr == A_W'(N - 1);
  assign w_col_wrap = r_col == C_W'(GRID_W - 1);
  assign w_final_wb = w_wr_en & ~w_any_valid;
  lbm_wb_delay #(.PIPE_LAT(PIPE_LAT), .A_W(A_W)) u_wb (
    .clk(Clk),
    .rst(Reset),
    .i_valid(w_accept),
    .i_addr(w_addr),
    .o_valid(w_wr_en),
    .o_addr(w_wr_addr),
    .o_any_valid(w_any_valid)
  );
  // state register
  always_ff @(posedge Clk) r_state <= Reset ? S_IDLE : w_next;
  // sweep sequencing: drains end when the last cell of the sweep writes back
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (num_steps == '0) ? S_DONE : S_COLLIDE;
      S_COLLIDE: if (w_accept && w_last_cell) w_next = S_DRAIN_C;
      S_DRAIN_C: if (w_final_wb) w_next = S_STREAM;
      S_STREAM:  if (w_accept && w_last_cell) w_next = S_DRAIN_S;
      S_DRAIN_S: if (w_final_wb) w_next = (r_step + STEP_WIDTH'(1) < r_num) ? S_COLLIDE : S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end
  // cell cursor, latched step target and completed-step counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_row <= '0;
      r_col <= '0;
      r_step <= '0;
      r_num <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_row <= '0;
      r_col <= '0;
      r_step <= '0;
      r_num <= num_steps;
    end else begin
      if (w_accept) begin
        r_col <= w_col_wrap ? '0 : r_col + C_W'(1);
        r_row <= w_last_cell ? '0 : w_col_wrap ? r_row + R_W'(1) : r_row;
      end
      if (r_state == S_DRAIN_S && w_final_wb) r_step <= r_step + STEP_WIDTH'(1);
    end
  end
  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = r_state == S_DONE;
  assign phase = (r_state == S_COLLIDE || r_state == S_DRAIN_C) ? PHASE_COLLIDE :
                 (r_state == S_STREAM || r_state == S_DRAIN_S) ? PHASE_STREAM : PHASE_IDLE;
  assign step_count = r_step;
  assign io.rd_valid = w_issue;
  assign io.rd_addr = w_addr;
  assign io.row = r_row;
  assign io.col = r_col;
  assign io.wr_en = w_wr_en;
  assign io.wr_addr = w_wr_addr;
`ifdef LBM_SWEEP_BOUNDARY_EN
  assign io.edge_flag = w_issue & (r_row == '0 || r_row == R_W'(GRID_H - 1) || r_col == '0 || w_col_wrap);
`else
  assign io.edge_flag = 1'b0;
`endif
endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// tb_lbm_sweep_ctrl: table-driven runs with a write-back scoreboard for lbm_sweep_ctrl
module tb_lbm_sweep_ctrl;
  localparam int W = 16;
  localparam int H = 16;
  localparam int NC = W * H;
  localparam int LAT = 3;
`ifdef LBM_SWEEP_BOUNDARY_EN
  localparam bit BND_EN = 1'b1;
`else
  localparam bit BND_EN = 1'b0;
`endif
  typedef struct { int n; int mode; int exp_done; int exp_rd; int exp_wr; int exp_s2; } vec_t;
  typedef struct { int addr; int due; } wb_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] num_steps = '0;
  logic busy, done;
  logic [1:0] phase;
  logic [15:0] step_count;
  int total = 0, bad = 0;
  int cyc = 0, t0 = 0, mode = 0;
  int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0, done_at = 0, s2_at = 0, exp_rd = 0;
  wb_t q[$];
  vec_t vecs[4];
  lbm_sweep_ctrl_if #(.GRID_W(W), .GRID_H(H)) ifc ();
  lbm_sweep_ctrl dut (
    .Clk(Clk),
    .Reset(Reset),
    .start(start),
    .num_steps(num_steps),
    .busy(busy),
    .done(done),
    .phase(phase),
    .step_count(step_count),
    .io(ifc)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc - t0);
    end
  endtask
  function automatic logic exp_edge(input int a);
    return BND_EN && (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1);
  endfunction
  task automatic tick();
    @(posedge Clk);
    #1;
    ifc.dp_ready = (mode == 0) ? 1'b1 : ((cyc - t0) % 2 == 1);
  endtask
  function automatic longint all_out();
    return 64'({busy, done, phase, step_count, ifc.rd_valid, ifc.rd_addr, ifc.row, ifc.col,
                ifc.wr_en, ifc.wr_addr, ifc.edge_flag});
  endfunction
  // monitor: checks issued addresses against the model cursor and matches write-backs to the scoreboard
  always @(negedge Clk) begin : mon
    wb_t e;
    if (Reset) begin
      q.delete();
      exp_rd = 0;
    end else begin
      if (ifc.wr_en) begin
        wr_cnt++;
        if (q.size() == 0) chk("wr_spurious", 64'(ifc.wr_en), 64'(0));
        else begin
          e = q.pop_front();
          chk("wr_addr", 64'(ifc.wr_addr), 64'(e.addr));
          chk("wr_cycle", 64'(cyc), 64'(e.due));
        end
      end
      chk("edge_flag", 64'(ifc.edge_flag), 64'(ifc.rd_valid ? exp_edge(exp_rd) : 1'b0));
      if (ifc.rd_valid) begin
        chk("rd_addr", 64'(ifc.rd_addr), 64'(exp_rd));
        chk("row", 64'(ifc.row), 64'(exp_rd / W));
        chk("col", 64'(ifc.col), 64'(exp_rd % W));
        if (ifc.dp_ready) begin
          q.push_back('{exp_rd, cyc + LAT});
          exp_rd = (exp_rd + 1) % NC;
          rd_cnt++;
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc - t0;
      end
      if (phase == 2'd2 && s2_at == 0) s2_at = cyc - t0;
    end
  end
  task automatic run(input vec_t v);
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; s2_at = 0;
    mode = v.mode;
    num_steps = 16'(v.n);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (done_at == 0 && cyc - t0 < 3000) begin
      tick();
      start = (cyc - t0 == 100);
      if (start) num_steps = 16'd7;
    end
    start = 1'b0;
    repeat (4) tick();
    chk("done_cycle", 64'(done_at), 64'(v.exp_done));
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("busy_cycles", 64'(busy_cnt), 64'(v.exp_done - 1));
    chk("rd_count", 64'(rd_cnt), 64'(v.exp_rd));
    chk("wr_count", 64'(wr_cnt), 64'(v.exp_wr));
    chk("stream_start", 64'(s2_at), 64'(v.exp_s2));
    chk("step_count", 64'(step_count), 64'(v.n));
    chk("pending_wb", 64'(q.size()), 64'(0));
  endtask
  initial begin
    int wr0;
    vecs[0] = '{0, 0, 1, 0, 0, 0};
    vecs[1] = '{1, 0, 519, 2 * NC, 2 * NC, 260};
    vecs[2] = '{1, 1, 1029, 2 * NC, 2 * NC, 515};
    vecs[3] = '{2, 0, 1037, 4 * NC, 4 * NC, 260};
    ifc.dp_ready = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_outputs", all_out(), 64'(0));
    end
    for (int i = 0; i < 4; i++) run(vecs[i]);
    mode = 0;
    num_steps = 16'd1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc - t0 < 300) tick();
    chk("phase_before_reset", 64'(phase), 64'(2));
    Reset = 1'b1;
    tick();
    chk("reset_outputs", all_out(), 64'(0));
    tick();
    chk("reset_hold_outputs", all_out(), 64'(0));
    Reset = 1'b0;
    wr0 = wr_cnt;
    repeat (8) tick();
    chk("wr_after_reset", 64'(wr_cnt), 64'(wr0));
    chk("idle_after_reset", all_out(), 64'(0));
    run(vecs[1]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
